// File: rtl/mem_arbiter_if.sv
// Unified-memory arbiter bus: the core's fetch (i*) and data (d*) request
// ports plus the single registered command port towards memory (mem*).
// slave = arbiter view; master = core plus memory (environment) view.
interface mem_arbiter_if #(
  parameter int AW = 32
);
  // fetch port
  logic          iReq;
  logic [AW-1:0] iAddr;
  logic [31:0]   iRData;
  logic          iReady;
  // data port
  logic          dReq;
  logic          dWe;
  logic [AW-1:0] dAddr;
  logic [31:0]   dWData;
  logic [31:0]   dRData;
  logic          dReady;
  // hazard-unit stalls
  logic          stallF;
  logic          stallM;
  // memory command / response
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memWData;
  logic [31:0]   memRData;

  modport slave (
    input  iReq, iAddr, dReq, dWe, dAddr, dWData, memRData,
    output iRData, iReady, dRData, dReady, stallF, stallM,
           memReq, memWe, memAddr, memWData
  );

  modport master (
    output iReq, iAddr, dReq, dWe, dAddr, dWData, memRData,
    input  iRData, iReady, dRData, dReady, stallF, stallM,
           memReq, memWe, memAddr, memWData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one fixed-latency memory between the MIPS fetch and data ports, round-robin on ties.
// Latency: memReq 1 cycle after a request is seen idle; ready at +LATENCY+2 (read) or +2 (write).
// Backpressure: one access at a time; the waiting port sees its stall held high until its ready pulse.
//
// Ports: clk, reset (synchronous, active high), bus (mem_arbiter_if.slave):
//   i*/d* request ports towards the core, stallF/stallM to the hazard unit,
//   mem* registered command port and memRData response from memory.
// LATENCY: cycles from the memReq cycle to valid memRData, legal range 1..15.
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          lastD_q, lastD_d;     // 1 = most recent grant went to D
  logic          owner_q, owner_d;     // 1 = current access belongs to D
  logic          isWrite_q, isWrite_d;
  logic          memReq_q, memReq_d;
  logic          memWe_q, memWe_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [31:0]   memWData_q, memWData_d;
  logic [31:0]   iRData_q, iRData_d;
  logic [31:0]   dRData_q, dRData_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lastD_d    = lastD_q;
    owner_d    = owner_q;
    isWrite_d  = isWrite_q;
    // memReq/memWe are single-cycle strobes: low unless a grant happens now
    memReq_d   = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWData_d = memWData_q;
    iRData_d   = iRData_q;
    dRData_d   = dRData_q;

    case (state_q)
      IDLE: begin
        // D wins unless I is also waiting and D had the previous grant
        if (bus.dReq && (!bus.iReq || !lastD_q)) begin
          memReq_d   = 1'b1;
          memWe_d    = bus.dWe;
          memAddr_d  = bus.dAddr;
          memWData_d = bus.dWData;
          owner_d    = 1'b1;
          lastD_d    = 1'b1;
          isWrite_d  = bus.dWe;
          cnt_d      = 4'd0;
          state_d    = DACC;
        end else if (bus.iReq) begin
          memReq_d   = 1'b1;
          memWe_d    = 1'b0;
          memAddr_d  = bus.iAddr;
          memWData_d = '0;
          owner_d    = 1'b0;
          lastD_d    = 1'b0;
          isWrite_d  = 1'b0;
          cnt_d      = 4'd0;
          state_d    = IACC;
        end
      end
      IACC, DACC: begin
        if (isWrite_q) begin
          // a store is done once memory has sampled the command
          state_d = DONE;
        end else begin
          // cnt counts cycles since the memReq cycle; data is valid at LAT
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAT) begin
            if (owner_q) dRData_d = bus.memRData;
            else         iRData_d = bus.memRData;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      lastD_q    <= 1'b0;
      owner_q    <= 1'b0;
      isWrite_q  <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWData_q <= '0;
      iRData_q   <= '0;
      dRData_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lastD_q    <= lastD_d;
      owner_q    <= owner_d;
      isWrite_q  <= isWrite_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWData_q <= memWData_d;
      iRData_q   <= iRData_d;
      dRData_q   <= dRData_d;
    end
  end

  // Ready pulses decode straight from the DONE state, so exactly one fires per access
  assign bus.iReady   = (state_q == DONE) && !owner_q;
  assign bus.dReady   = (state_q == DONE) &&  owner_q;
  assign bus.stallF   = bus.iReq && !bus.iReady;
  assign bus.stallM   = bus.dReq && !bus.dReady;
  assign bus.memReq   = memReq_q;
  assign bus.memWe    = memWe_q;
  assign bus.memAddr  = memAddr_q;
  assign bus.memWData = memWData_q;
  assign bus.iRData   = iRData_q;
  assign bus.dRData   = dRData_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-count reference model; extra LATENCY=1 and LATENCY=15 DUTs.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int L  = 2;
  localparam logic [31:0] BAD        = 32'hBAD0BAD0;
  localparam logic [31:0] FETCH_WORD = 32'h20020005;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW)) bus ();
  mem_arbiter_if #(.AW(AW)) b1 ();
  mem_arbiter_if #(.AW(AW)) b15 ();

  mem_arbiter #(.LATENCY(L),  .AW(AW)) u_dut   (.clk(clk), .reset(reset), .bus(bus.slave));
  mem_arbiter #(.LATENCY(1),  .AW(AW)) u_dut1  (.clk(clk), .reset(reset), .bus(b1.slave));
  mem_arbiter #(.LATENCY(15), .AW(AW)) u_dut15 (.clk(clk), .reset(reset), .bus(b15.slave));

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_drdata = '0;

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return FETCH_WORD;   // byte address 0x40
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010203);
  endfunction

  // ---------------- memory models ----------------
  logic [31:0] mem [0:63];
  int          cyc    = 0;
  int          rd_due = -100;
  logic [31:0] rd_dat = '0;
  int          due1   = -100;
  int          due15  = -100;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      rd_due <= -100;
      due1   <= -100;
      due15  <= -100;
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else begin
      if (bus.memReq) begin
        if (bus.memWe) mem[bus.memAddr[7:2]] <= bus.memWData;
        else begin
          rd_due <= cyc + L;
          rd_dat <= mem[bus.memAddr[7:2]];
        end
      end
      if (b1.memReq)  due1  <= cyc + 1;
      if (b15.memReq) due15 <= cyc + 15;
    end
  end

  // Read data appears only in the one cycle it is guaranteed valid
  assign bus.memRData = (cyc == rd_due) ? rd_dat : BAD;
  assign b1.memRData  = (cyc == due1)   ? FETCH_WORD : BAD;
  assign b15.memRData = (cyc == due15)  ? FETCH_WORD : BAD;

  task automatic ref_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    exp_drdata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [2:0] got, exp;
    bus.iReq = 1'b1; bus.dReq = 1'b1; bus.iAddr = 32'h44; bus.dAddr = 32'h50;
    bus.dWe = 1'b0; bus.dWData = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      reset = (c < 2);
      if (c == 0) ref_reset();
      if (c == 3) bus.iReq = 1'b0;
      if (c == 7) bus.dReq = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if ({bus.memReq, bus.memWe, bus.iReady, bus.dReady} !== 4'b0)
          $display("FAIL reset_ctl: got %b want 0000", {bus.memReq, bus.memWe, bus.iReady, bus.dReady});
        else n_pass++;
        n_checks++;
        if ({bus.memAddr, bus.memWData} !== 64'b0)
          $display("FAIL reset_cmd: got addr %h wdata %h want 0", bus.memAddr, bus.memWData);
        else n_pass++;
        n_checks++;
        if ({bus.iRData, bus.dRData} !== 64'b0)
          $display("FAIL reset_rdata: got i %h d %h want 0", bus.iRData, bus.dRData);
        else n_pass++;
      end
      if (c >= 2) begin
        got = {bus.memReq, bus.dReady, bus.iReady};
        exp = {c == 3, c == 6, 1'b0};
        n_checks++;
        if (got !== exp) $display("FAIL reset_first_grant c=%0d: got %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 3) begin
        n_checks++;
        if ({bus.memWe, bus.memAddr} !== {1'b0, 32'h50})
          $display("FAIL reset_d_wins: got we %b addr %h want 0 00000050", bus.memWe, bus.memAddr);
        else n_pass++;
      end
      if (c == 6) begin
        exp_drdata = ref_mem[20];
        n_checks++;
        if (bus.dRData !== exp_drdata) $display("FAIL reset_load_data: got %h want %h", bus.dRData, exp_drdata);
        else n_pass++;
      end
    end
  endtask

  task automatic test_store();
    logic [3:0] got, exp;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 32'h54; bus.dWData = 32'd7;
        ref_mem[21] = 32'd7;
      end
      if (c == 3) begin bus.dReq = 1'b0; bus.dWe = 1'b0; end
      @(negedge clk);
      got = {bus.memReq, bus.dReady, bus.iReady, bus.stallM};
      exp = {c == 1, c == 2, 1'b0, c < 2};
      n_checks++;
      if (got !== exp) $display("FAIL store_ctl c=%0d: got %b want %b", c, got, exp);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if ({bus.memWe, bus.memAddr, bus.memWData} !== {1'b1, 32'h54, 32'd7})
          $display("FAIL store_cmd: got we %b addr %h wd %h want 1 00000054 00000007",
                   bus.memWe, bus.memAddr, bus.memWData);
        else n_pass++;
      end
      if (c == 2) begin
        n_checks++;
        if (bus.dRData !== exp_drdata) $display("FAIL store_drdata_kept: got %h want %h", bus.dRData, exp_drdata);
        else n_pass++;
      end
    end
  endtask

  task automatic test_single_fetch();
    logic [3:0] got, exp;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin bus.iReq = 1'b1; bus.iAddr = 32'h40; end
      if (c == 5) bus.iReq = 1'b0;
      @(negedge clk);
      got = {bus.memReq, bus.iReady, bus.dReady, bus.stallF};
      exp = {c == 1, c == L + 2, 1'b0, c < L + 2};
      n_checks++;
      if (got !== exp) $display("FAIL fetch_ctl c=%0d: got %b want %b", c, got, exp);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if ({bus.memWe, bus.memAddr} !== {1'b0, 32'h40})
          $display("FAIL fetch_cmd: got we %b addr %h want 0 00000040", bus.memWe, bus.memAddr);
        else n_pass++;
      end
      if (c >= L + 2) begin
        n_checks++;
        if (bus.iRData !== FETCH_WORD) $display("FAIL fetch_data c=%0d: got %h want %h", c, bus.iRData, FETCH_WORD);
        else n_pass++;
      end
    end
  endtask

  task automatic test_contention();
    logic [4:0] got, exp;
    int  ph;
    bit  is_d, live, rdy;
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.iAddr = 32'h0; bus.dAddr = 32'h50; bus.dWe = 1'b0;
        bus.iReq = 1'b1; bus.dReq = 1'b1;
      end
      if (c == 20) begin bus.iReq = 1'b0; bus.dReq = 1'b0; end
      @(negedge clk);
      // each access occupies a 5-cycle slot; slots alternate D, I, D, I
      ph   = c % 5;
      is_d = ((c / 5) % 2) == 0;
      live = c < 20;
      rdy  = (ph == 4);
      got = {bus.memReq, bus.iReady, bus.dReady, bus.stallF, bus.stallM};
      exp = {ph == 1 && live, rdy && !is_d, rdy && is_d, live && !(rdy && !is_d), live && !(rdy && is_d)};
      n_checks++;
      if (got !== exp) $display("FAIL contention_ctl c=%0d: got %b want %b", c, got, exp);
      else n_pass++;
      if (ph == 1 && live) begin
        n_checks++;
        if (bus.memAddr !== (is_d ? 32'h50 : 32'h0))
          $display("FAIL contention_order c=%0d: got addr %h want %h", c, bus.memAddr, is_d ? 32'h50 : 32'h0);
        else n_pass++;
      end
      if (rdy && is_d) begin
        exp_drdata = ref_mem[20];
        n_checks++;
        if (bus.dRData !== exp_drdata) $display("FAIL contention_ddata c=%0d: got %h want %h", c, bus.dRData, exp_drdata);
        else n_pass++;
      end
      if (rdy && !is_d) begin
        n_checks++;
        if (bus.iRData !== ref_mem[0]) $display("FAIL contention_idata c=%0d: got %h want %h", c, bus.iRData, ref_mem[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] got, exp;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h58; end
      if (c == 2) begin reset = 1'b1; bus.dReq = 1'b0; ref_reset(); end
      if (c == 3) reset = 1'b0;
      if (c == 8) begin bus.iReq = 1'b1; bus.iAddr = 32'h40; end
      if (c == 13) bus.iReq = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if ({bus.memReq, bus.memAddr} !== {1'b1, 32'h58})
          $display("FAIL midrst_issue: got req %b addr %h want 1 00000058", bus.memReq, bus.memAddr);
        else n_pass++;
      end
      if (c >= 3 && c <= 7) begin
        n_checks++;
        if ({bus.memReq, bus.dReady, bus.iReady, bus.dRData, bus.iRData} !== 67'b0)
          $display("FAIL midrst_quiet c=%0d: got req %b dr %b ir %b drd %h ird %h want all 0",
                   c, bus.memReq, bus.dReady, bus.iReady, bus.dRData, bus.iRData);
        else n_pass++;
      end
      if (c >= 8) begin
        got = {bus.memReq, bus.iReady};
        exp = {c == 9, c == 12};
        n_checks++;
        if (got !== exp) $display("FAIL midrst_refetch c=%0d: got %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 12) begin
        n_checks++;
        if (bus.iRData !== FETCH_WORD) $display("FAIL midrst_refetch_data: got %h want %h", bus.iRData, FETCH_WORD);
        else n_pass++;
      end
    end
  endtask

  // Random traffic: each port raises a request at random, holds it until its
  // ready pulse, then drops it. The model tracks when the arbiter is free and
  // predicts grants, command cycles, ready cycles and returned data.
  task automatic test_random(input int n_cyc);
    bit          ip, dp, dw, m_idle, m_lastD, m_own, m_we, e_ir, e_dr;
    logic [31:0] ia, da, dd, m_addr, m_wd, m_dat, last_ld;
    int          m_mreq, m_rdy;
    logic [4:0]  got, exp;
    ip = 0; dp = 0; dw = 0; ia = '0; da = '0; dd = '0;
    m_idle = 1; m_lastD = 0; m_own = 0; m_we = 0; m_addr = '0; m_wd = '0; m_dat = '0;
    m_mreq = -1; m_rdy = -1; last_ld = '0;
    bus.iReq = 1'b0; bus.dReq = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      reset = (c == 0);
      if (c == 0) ref_reset();
    end
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk); #1;
      if (!ip && $urandom_range(0, 99) < 40) begin
        ip = 1; ia = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dp && $urandom_range(0, 99) < 40) begin
        dp = 1; da = 32'($urandom_range(0, 63)) << 2;
        dw = $urandom_range(0, 1) == 1; dd = $urandom;
      end
      bus.iReq = ip; bus.iAddr = ia;
      bus.dReq = dp; bus.dAddr = da; bus.dWe = dw; bus.dWData = dd;
      if (m_idle && (ip || dp)) begin
        m_own   = dp && (!ip || !m_lastD);
        m_lastD = m_own;
        m_idle  = 0;
        m_mreq  = c + 1;
        if (m_own) begin
          m_addr = da; m_we = dw; m_wd = dd;
          if (dw) begin ref_mem[da[7:2]] = dd; m_rdy = c + 2; end
          else begin m_dat = ref_mem[da[7:2]]; m_rdy = c + L + 2; end
        end else begin
          m_addr = ia; m_we = 0; m_wd = '0;
          m_dat = ref_mem[ia[7:2]]; m_rdy = c + L + 2;
        end
      end
      @(negedge clk);
      e_ir = (c == m_rdy) && !m_own;
      e_dr = (c == m_rdy) &&  m_own;
      got = {bus.memReq, bus.iReady, bus.dReady, bus.stallF, bus.stallM};
      exp = {c == m_mreq, e_ir, e_dr, ip && !e_ir, dp && !e_dr};
      n_checks++;
      if (got !== exp) $display("FAIL rand_ctl c=%0d: got %b want %b", c, got, exp);
      else n_pass++;
      if (c == m_mreq) begin
        n_checks++;
        if ({bus.memWe, bus.memAddr} !== {m_we, m_addr})
          $display("FAIL rand_cmd c=%0d: got we %b addr %h want %b %h", c, bus.memWe, bus.memAddr, m_we, m_addr);
        else n_pass++;
        if (m_we) begin
          n_checks++;
          if (bus.memWData !== m_wd) $display("FAIL rand_wdata c=%0d: got %h want %h", c, bus.memWData, m_wd);
          else n_pass++;
        end
      end
      if (e_ir) begin
        n_checks++;
        if (bus.iRData !== m_dat) $display("FAIL rand_idata c=%0d: got %h want %h", c, bus.iRData, m_dat);
        else n_pass++;
      end
      if (e_dr) begin
        if (!m_we) last_ld = m_dat;
        n_checks++;
        if (bus.dRData !== last_ld) $display("FAIL rand_ddata c=%0d: got %h want %h", c, bus.dRData, last_ld);
        else n_pass++;
      end
      if (c == m_rdy) begin
        m_idle = 1;
        if (m_own) dp = 0; else ip = 0;
      end
    end
    bus.iReq = 1'b0; bus.dReq = 1'b0;
    for (int c = 0; c < 20; c++) @(posedge clk);
    #1;
  endtask

  task automatic test_latency_builds();
    logic [1:0] got1, exp1, got15, exp15;
    for (int c = 0; c < 19; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        b1.iReq = 1'b1;  b1.iAddr = 32'h40;
        b15.iReq = 1'b1; b15.iAddr = 32'h40;
      end
      if (c == 4)  b1.iReq = 1'b0;
      if (c == 18) b15.iReq = 1'b0;
      @(negedge clk);
      got1  = {b1.memReq, b1.iReady};
      exp1  = {c == 1, c == 3};
      got15 = {b15.memReq, b15.iReady};
      exp15 = {c == 1, c == 17};
      n_checks++;
      if (got1 !== exp1) $display("FAIL lat1_ctl c=%0d: got %b want %b", c, got1, exp1);
      else n_pass++;
      n_checks++;
      if (got15 !== exp15) $display("FAIL lat15_ctl c=%0d: got %b want %b", c, got15, exp15);
      else n_pass++;
      if (c == 3) begin
        n_checks++;
        if (b1.iRData !== FETCH_WORD) $display("FAIL lat1_data: got %h want %h", b1.iRData, FETCH_WORD);
        else n_pass++;
      end
      if (c == 17) begin
        n_checks++;
        if (b15.iRData !== FETCH_WORD) $display("FAIL lat15_data: got %h want %h", b15.iRData, FETCH_WORD);
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.iReq = 1'b0; bus.iAddr = '0; bus.dReq = 1'b0; bus.dWe = 1'b0; bus.dAddr = '0; bus.dWData = '0;
    b1.iReq  = 1'b0; b1.iAddr  = '0; b1.dReq  = 1'b0; b1.dWe  = 1'b0; b1.dAddr  = '0; b1.dWData  = '0;
    b15.iReq = 1'b0; b15.iAddr = '0; b15.dReq = 1'b0; b15.dWe = 1'b0; b15.dAddr = '0; b15.dWData = '0;
    ref_reset();
    test_reset();
    test_store();
    test_single_fetch();
    test_contention();
    test_mid_reset();
    test_random(600);
    test_latency_builds();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
